shared_mult_unit: RTL
=====================

Name: shared_mult_unit

Overview:
- Shared signed sequential (shift-add) multiplier with a round-robin arbiter, serving all neurons of one layer.
- Sits directly downstream of each neuron's multiplier port. Neurons raise req+start with operands, wait for grant, then wait for done, accumulate the result and drop req.
- One multiply in flight at a time. Result and done are routed only to the granted requester.

Parameters:
- NumRequesters, 5, number of neuron ports (≥2)
- DataWidth, 8, operand width in bits (signed two's complement); product is 2*DataWidth

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- req_i  in  NumRequesters  per-neuron multiplier request (mutex)
- start_i  in  NumRequesters  per-neuron start; held high until granted
- a_i  in  NumRequesters*DataWidth  operand A, slice k = requester k
- b_i  in  NumRequesters*DataWidth  operand B, slice k = requester k
- grant_o  out  NumRequesters  one-hot grant
- done_o  out  NumRequesters  one-cycle done pulse to owner
- busy_o  out  1  unit owned or computing
- result_o  out  2*DataWidth  signed product, held until next done

Behaviour:
- Reset (async assert, sync release): state IDLE; grant_o=0; done_o=0; busy_o=0; result_o=0; rr pointer=0; accumulator, counter and operand registers=0.
- Eligible requester k: req_i[k] & start_i[k].
- States: IDLE, LOAD, BUSY, DONE, RELEASE.
- IDLE, any eligible: winner = first eligible scanning from ptr upward with wrap. grant_o[winner]<=1, busy_o<=1, go LOAD. No eligible: stay.
- LOAD:
  - Latch a_i/b_i slice of owner as magnitudes |A|, |B|.
  - Latch sign = sA^sB.
  - Clear accumulator and counter. Go BUSY.
  - |-2^(DW-1)| is taken as unsigned 2^(DW-1); no overflow.
- BUSY: one multiplier bit per cycle (LSB first). If bit set, add shifted |A| to accumulator. Count DataWidth cycles, then go DONE.
- DONE: result_o <= sign ? -acc : acc (2*DataWidth bits). done_o[owner]<=1 for exactly one cycle. Go RELEASE.
- RELEASE: done_o<=0. When req_i[owner]==0: grant_o<=0, busy_o<=0, ptr<=owner+1 (wrap to 0 after NumRequesters-1), go IDLE. If req is still high, hold grant.
- Latency: grant_o rises 1 cycle after the eligible req is sampled. done_o rises DataWidth+2 cycles after grant_o rises (10 for DataWidth=8). result_o is valid in the same cycle as done_o.
- Abort: req_i[owner] falls in LOAD/BUSY/DONE → next cycle grant_o=0, busy_o=0, done_o=0, no done pulse, result_o unchanged, ptr advances, go IDLE.
- start_i[owner] changing after grant: ignored.
- Operand changes after LOAD: ignored.
- Non-owner req/start while busy: ignored until IDLE; requesters keep req high and wait.
- Simultaneous requests: exactly one grant; never more than one grant_o bit set.
- Max product (-2^(DW-1))^2 = 2^(2DW-2): fits signed 2*DataWidth.
- Async reset mid-operation: immediate return to reset values, no done pulse.

Test Plan:
- Single req k=1, a=3, b=5 → grant_o=0b00010 one cycle later; done_o[1] pulses 10 cycles after grant; result_o=16'h000F; grant drops the cycle after req falls.
- Signs: (-7)*6 → 16'hFFD6; (-128)*(-128) → 16'h4000; 127*(-128) → 16'hC080; 0*(-5) → 16'h0000.
- Round-robin, ptr=0: req 0 and 2 together → 0 served then 2. Then req 0 and 3 together → 3 first (ptr=3), then 0.
- Abort: owner drops req at 4th BUSY cycle → no done_o, result_o keeps previous value, next requester granted 2 cycles later.
- Owner holds req 3 cycles after done → grant held, no second done, no other grant. Another requester meanwhile is granted only after release.
- reset_ni low mid-BUSY (async, between edges) → outputs zero immediately. After release, a fresh 3*5 returns 16'h000F with nominal latency.

Source files
------------

// File: rtl/shared_mult_unit.sv
// Shared signed shift-add multiplier behind a round-robin arbiter. One neuron
// port owns the unit at a time; the product and the done pulse go only to that owner.
module shared_mult_unit #(
  parameter int NumRequesters = 5,
  parameter int DataWidth     = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic [NumRequesters-1:0]           req_i,
  input  logic [NumRequesters-1:0]           start_i,
  input  logic [NumRequesters*DataWidth-1:0] a_i,
  input  logic [NumRequesters*DataWidth-1:0] b_i,
  output logic [NumRequesters-1:0]           grant_o,
  output logic [NumRequesters-1:0]           done_o,
  output logic                               busy_o,
  output logic [2*DataWidth-1:0]             result_o
);

  localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int CntW = $clog2(DataWidth + 1);
  localparam int PW   = 2 * DataWidth;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StBusy    = 3'd2;
  localparam logic [2:0] StDone    = 3'd3;
  localparam logic [2:0] StRelease = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [IdxW-1:0]          owner_q, owner_d;
  logic [NumRequesters-1:0] grant_q, grant_d;
  logic [NumRequesters-1:0] done_q, done_d;
  logic                     busy_q, busy_d;
  logic [PW-1:0]            result_q, result_d;
  logic [PW-1:0]            acc_q, acc_d;
  logic [PW-1:0]            mcand_q, mcand_d;
  logic [DataWidth-1:0]     mplier_q, mplier_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     sign_q, sign_d;

  logic [NumRequesters-1:0] eligible;
  logic                     eligible_any;
  logic [IdxW-1:0]          winner;
  int                       scan_idx;

  logic [DataWidth-1:0]     op_a, op_b, mag_a, mag_b;
  logic [IdxW-1:0]          next_ptr;
  logic                     owner_req;

  assign eligible = req_i & start_i;

  // First eligible requester at or after the pointer, wrapping around.
  always_comb begin
    eligible_any = 1'b0;
    winner       = '0;
    scan_idx     = 0;
    for (int i = 0; i < NumRequesters; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NumRequesters) scan_idx = scan_idx - NumRequesters;
      if (!eligible_any && eligible[scan_idx]) begin
        eligible_any = 1'b1;
        winner       = IdxW'(scan_idx);
      end
    end
  end

  // Magnitudes fit in DataWidth unsigned bits, so |-2^(DW-1)| needs no extra bit.
  assign op_a      = a_i[int'(owner_q)*DataWidth +: DataWidth];
  assign op_b      = b_i[int'(owner_q)*DataWidth +: DataWidth];
  assign mag_a     = op_a[DataWidth-1] ? (~op_a + DataWidth'(1)) : op_a;
  assign mag_b     = op_b[DataWidth-1] ? (~op_b + DataWidth'(1)) : op_b;
  assign next_ptr  = (int'(owner_q) == NumRequesters - 1) ? '0 : owner_q + 1'b1;
  assign owner_req = req_i[owner_q];

  // NOTE: every signal assigned here gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;

    case (state_q)
      StIdle: begin
        if (eligible_any) begin
          grant_d = NumRequesters'(1) << winner;
          busy_d  = 1'b1;
          owner_d = winner;
          state_d = StLoad;
        end
      end
      StLoad, StBusy, StDone, StRelease: begin
        if (!owner_req) begin
          // Owner dropped req: abort or normal release look the same from outside.
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
          state_d = StIdle;
        end else if (state_q == StLoad) begin
          mcand_d  = {{DataWidth{1'b0}}, mag_a};
          mplier_d = mag_b;
          sign_d   = op_a[DataWidth-1] ^ op_b[DataWidth-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StBusy;
        end else if (state_q == StBusy) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DataWidth - 1)) state_d = StDone;
        end else if (state_q == StDone) begin
          result_d        = sign_q ? (~acc_q + PW'(1)) : acc_q;
          done_d[owner_q] = 1'b1;
          state_d         = StRelease;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // NOTE: datapath registers are reset too, so the unit restarts from a fully known state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all registers see the same pre-edge values.
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end

  assign grant_o  = grant_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign result_o = result_q;

endmodule
